ring_osc_sweeper: RTL



---
 rtl/ring_osc_pkg.sv | 38 +++
 rtl/ring_edge_sync.sv | 27 ++
 rtl/ring_osc_sweeper.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/ring_osc_pkg.sv
// Shared state encoding, default sizing and ring-selection helper for the ring-oscillator sweeper.
package ring_osc_pkg;

    localparam int DEF_NUM_RINGS = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int DEF_SETTLE_W  = 8;
    localparam int DEF_WINDOW_W  = 16;
    localparam int MAX_RINGS     = 32;

    typedef enum logic [1:0] {
        IDLE,
        SETTLE,
        MEASURE,
        REPORT
    } sweep_state_e;

    // Lowest set mask bit at index >= first; with wrap, falls back to the lowest set bit overall.
    // Returns -1 when nothing qualifies.
    function automatic int pick_ring(input logic [MAX_RINGS-1:0] mask, input int first,
                                     input logic wrap);
        int pick;
        pick = -1;
        for (int i = MAX_RINGS - 1; i >= 0; i--) begin
            if (mask[i] && i >= first) begin
                pick = i;
            end
        end
        if (pick < 0 && wrap) begin
            for (int i = MAX_RINGS - 1; i >= 0; i--) begin
                if (mask[i]) begin
                    pick = i;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Brings one pre-divided ring output into the clk domain and flags its rising edges.
module ring_edge_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic ring_in,
    output logic rise
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= ring_in;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign rise = sync_q & ~prev_q;

endmodule

// File: rtl/ring_osc_sweeper.sv
// Sweeps the on-die ring oscillators one at a time: enable, settle, count edges over a window, report.
module ring_osc_sweeper
    import ring_osc_pkg::*;
#(
    parameter int  NUM_RINGS = DEF_NUM_RINGS,
    parameter int  CNT_W     = DEF_CNT_W,
    parameter int  SETTLE_W  = DEF_SETTLE_W,
    parameter int  WINDOW_W  = DEF_WINDOW_W,
    localparam int IDX_W     = (NUM_RINGS > 1) ? $clog2(NUM_RINGS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 continuous,
    input  logic [NUM_RINGS-1:0] ring_mask,
    input  logic [SETTLE_W-1:0]  settle_cycles,
    input  logic [WINDOW_W-1:0]  window_cycles,
    input  logic                 stop,
    input  logic [NUM_RINGS-1:0] ring_in,
    output logic [NUM_RINGS-1:0] ring_en,
    output logic                 busy,
    output logic                 result_valid,
    output logic [IDX_W-1:0]     result_idx,
    output logic [CNT_W-1:0]     result_count,
    output logic                 result_ovf,
    output logic                 done
);

    sweep_state_e         state_q, state_d;
    logic [IDX_W-1:0]     sel_q, sel_d;
    logic                 cont_q, cont_d;
    logic [NUM_RINGS-1:0] mask_q, mask_d;
    logic [SETTLE_W-1:0]  settle_q, settle_d, settle_cnt_q, settle_cnt_d;
    logic [WINDOW_W-1:0]  window_q, window_d, window_cnt_q, window_cnt_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [NUM_RINGS-1:0] ring_en_q, ring_en_d;
    logic                 busy_q, busy_d;
    logic                 result_valid_q, result_valid_d;
    logic [IDX_W-1:0]     result_idx_q, result_idx_d;
    logic [CNT_W-1:0]     result_count_q, result_count_d;
    logic                 result_ovf_q, result_ovf_d;
    logic                 done_q, done_d;

    logic [NUM_RINGS-1:0] rise;
    logic [MAX_RINGS-1:0] start_mask_ext, mask_ext;
    int                   first_pick, next_pick;

    for (genvar g = 0; g < NUM_RINGS; g++) begin : g_sync
        ring_edge_sync u_sync (
            .clk     (clk),
            .rst_n   (rst_n),
            .ring_in (ring_in[g]),
            .rise    (rise[g])
        );
    end

    always_comb begin
        start_mask_ext                  = '0;
        start_mask_ext[NUM_RINGS-1:0]   = ring_mask;
        mask_ext                        = '0;
        mask_ext[NUM_RINGS-1:0]         = mask_q;
        first_pick = pick_ring(start_mask_ext, 0, 1'b0);
        next_pick  = pick_ring(mask_ext, int'(sel_q) + 1, cont_q);
    end

    // NOTE: every _d gets its hold value before the case so no path through it infers a latch.
    always_comb begin
        state_d        = state_q;
        sel_d          = sel_q;
        cont_d         = cont_q;
        mask_d         = mask_q;
        settle_d       = settle_q;
        window_d       = window_q;
        settle_cnt_d   = settle_cnt_q;
        window_cnt_d   = window_cnt_q;
        count_d        = count_q;
        ovf_d          = ovf_q;
        result_valid_d = 1'b0;
        result_idx_d   = result_idx_q;
        result_count_d = result_count_q;
        result_ovf_d   = result_ovf_q;
        done_d         = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    cont_d   = continuous;
                    mask_d   = ring_mask;
                    settle_d = settle_cycles;
                    window_d = window_cycles;
                    if (first_pick >= 0) begin
                        state_d      = SETTLE;
                        sel_d        = IDX_W'(first_pick);
                        settle_cnt_d = settle_cycles;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= SETTLE_W'(1)) begin
                    if (window_q == '0) begin
                        state_d        = REPORT;
                        result_valid_d = 1'b1;
                        result_idx_d   = sel_q;
                        result_count_d = '0;
                        result_ovf_d   = 1'b0;
                    end else begin
                        state_d      = MEASURE;
                        window_cnt_d = window_q;
                        count_d      = '0;
                        ovf_d        = 1'b0;
                    end
                end else begin
                    settle_cnt_d = settle_cnt_q - SETTLE_W'(1);
                end
            end
            MEASURE: begin
                if (rise[sel_q]) begin
                    if (&count_q) ovf_d = 1'b1;
                    else          count_d = count_q + CNT_W'(1);
                end
                window_cnt_d = window_cnt_q - WINDOW_W'(1);
                // The final window cycle's edge lands in the reported count.
                if (window_cnt_q <= WINDOW_W'(1)) begin
                    state_d        = REPORT;
                    result_valid_d = 1'b1;
                    result_idx_d   = sel_q;
                    result_count_d = count_d;
                    result_ovf_d   = ovf_d;
                end
            end
            REPORT: begin
                if (next_pick >= 0) begin
                    state_d      = SETTLE;
                    sel_d        = IDX_W'(next_pick);
                    settle_cnt_d = settle_q;
                end else begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort discards whatever result the current cycle would have produced.
        if (stop && state_q != IDLE) begin
            state_d        = IDLE;
            done_d         = 1'b1;
            result_valid_d = 1'b0;
            result_idx_d   = result_idx_q;
            result_count_d = result_count_q;
            result_ovf_d   = result_ovf_q;
        end

        ring_en_d = '0;
        if (state_d == SETTLE || state_d == MEASURE) ring_en_d[sel_d] = 1'b1;
        busy_d = (state_d != IDLE);
    end

    // NOTE: state registers use non-blocking assignments so all flops sample pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            sel_q          <= '0;
            cont_q         <= 1'b0;
            mask_q         <= '0;
            settle_q       <= '0;
            window_q       <= '0;
            settle_cnt_q   <= '0;
            window_cnt_q   <= '0;
            count_q        <= '0;
            ovf_q          <= 1'b0;
            ring_en_q      <= '0;
            busy_q         <= 1'b0;
            result_valid_q <= 1'b0;
            result_idx_q   <= '0;
            result_count_q <= '0;
            result_ovf_q   <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            sel_q          <= sel_d;
            cont_q         <= cont_d;
            mask_q         <= mask_d;
            settle_q       <= settle_d;
            window_q       <= window_d;
            settle_cnt_q   <= settle_cnt_d;
            window_cnt_q   <= window_cnt_d;
            count_q        <= count_d;
            ovf_q          <= ovf_d;
            ring_en_q      <= ring_en_d;
            busy_q         <= busy_d;
            result_valid_q <= result_valid_d;
            result_idx_q   <= result_idx_d;
            result_count_q <= result_count_d;
            result_ovf_q   <= result_ovf_d;
            done_q         <= done_d;
        end
    end

    assign ring_en      = ring_en_q;
    assign busy         = busy_q;
    assign result_valid = result_valid_q;
    assign result_idx   = result_idx_q;
    assign result_count = result_count_q;
    assign result_ovf   = result_ovf_q;
    assign done         = done_q;

endmodule
